// File: rtl/uart_alu_core.sv
// Serial calculator datapath: UART receiver, UART transmitter
// and a registered 8-bit arithmetic unit sharing one clock.
module uart_alu_core #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic                 data_ready,
  output logic [DBITS-1:0]     data_out,
  input  logic                 tx_start,
  input  logic [DBITS-1:0]     data_in,
  output logic                 tx_done,
  output logic                 tx,
  input  logic [DBITS-1:0]     number1,
  input  logic [DBITS-1:0]     number2,
  input  logic [2:0]           sel,
  output logic [2*DBITS-2:0]   alu_out
);

  localparam int AW = 2*DBITS-1;
  localparam int CW = $clog2(SB_TICK + 16);
  localparam int NW = $clog2(DBITS + 1);

  localparam logic [CW-1:0] S_ONE  = CW'(1);
  localparam logic [CW-1:0] S_MID  = CW'(7);
  localparam logic [CW-1:0] S_BIT  = CW'(15);
  localparam logic [CW-1:0] S_STOP = CW'(SB_TICK-1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS-1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } uart_st_e;

  // ---------------- receiver ----------------
  uart_st_e         rx_st, rx_st_n;
  logic [CW-1:0]    rx_s, rx_s_n;
  logic [NW-1:0]    rx_n, rx_n_n;
  logic [DBITS-1:0] rx_b, rx_b_n;
  logic             rx_fin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st      <= IDLE;
      rx_s       <= '0;
      rx_n       <= '0;
      rx_b       <= '0;
      data_ready <= 1'b0;
      data_out   <= '0;
    end else begin
      rx_st      <= rx_st_n;
      rx_s       <= rx_s_n;
      rx_n       <= rx_n_n;
      rx_b       <= rx_b_n;
      data_ready <= rx_fin;
      if (rx_fin) data_out <= rx_b;
    end
  end

  always_comb begin
    rx_st_n = rx_st;
    rx_s_n  = rx_s;
    rx_n_n  = rx_n;
    rx_b_n  = rx_b;
    rx_fin  = 1'b0;
    unique case (rx_st)
      IDLE: begin
        if (!rx) begin
          rx_st_n = START;
          rx_s_n  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (rx_s == S_MID) begin
            rx_st_n = DATA;
            rx_s_n  = '0;
            rx_n_n  = '0;
          end else begin
            rx_s_n = rx_s + S_ONE;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (rx_s == S_BIT) begin
            rx_s_n = '0;
            rx_b_n = {rx, rx_b[DBITS-1:1]};
            if (rx_n == N_LAST) rx_st_n = STOP;
            else                rx_n_n  = rx_n + N_ONE;
          end else begin
            rx_s_n = rx_s + S_ONE;
          end
        end
      end
      STOP: begin
        // stop level is deliberately not checked
        if (sample_tick) begin
          if (rx_s == S_STOP) begin
            rx_st_n = IDLE;
            rx_fin  = 1'b1;
          end else begin
            rx_s_n = rx_s + S_ONE;
          end
        end
      end
      default: rx_st_n = IDLE;
    endcase
  end

  // ---------------- transmitter ----------------
  uart_st_e         tx_st, tx_st_n;
  logic [CW-1:0]    tx_s, tx_s_n;
  logic [NW-1:0]    tx_n, tx_n_n;
  logic [DBITS-1:0] tx_b, tx_b_n;
  logic             tx_fin;
  logic             tx_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st   <= IDLE;
      tx_s    <= '0;
      tx_n    <= '0;
      tx_b    <= '0;
      tx_done <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_s    <= tx_s_n;
      tx_n    <= tx_n_n;
      tx_b    <= tx_b_n;
      tx_done <= tx_fin;
      tx      <= tx_nxt;
    end
  end

  always_comb begin
    tx_st_n = tx_st;
    tx_s_n  = tx_s;
    tx_n_n  = tx_n;
    tx_b_n  = tx_b;
    tx_fin  = 1'b0;
    unique case (tx_st)
      IDLE: begin
        if (tx_start) begin
          tx_st_n = START;
          tx_s_n  = '0;
          tx_b_n  = data_in;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tx_s == S_BIT) begin
            tx_st_n = DATA;
            tx_s_n  = '0;
            tx_n_n  = '0;
          end else begin
            tx_s_n = tx_s + S_ONE;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tx_s == S_BIT) begin
            tx_s_n = '0;
            tx_b_n = tx_b >> 1;
            if (tx_n == N_LAST) tx_st_n = STOP;
            else                tx_n_n  = tx_n + N_ONE;
          end else begin
            tx_s_n = tx_s + S_ONE;
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (tx_s == S_STOP) begin
            tx_st_n = IDLE;
            tx_fin  = 1'b1;
          end else begin
            tx_s_n = tx_s + S_ONE;
          end
        end
      end
      default: tx_st_n = IDLE;
    endcase
  end

  // line level follows the next state so tx comes from a flop
  always_comb begin
    tx_nxt = 1'b1;
    if (tx_st_n == START)     tx_nxt = 1'b0;
    else if (tx_st_n == DATA) tx_nxt = tx_b_n[0];
  end

  // ---------------- arithmetic unit ----------------
  logic [AW-1:0] op_a, op_b, res;

  assign op_a = {{(AW-DBITS){1'b0}}, number1};
  assign op_b = {{(AW-DBITS){1'b0}}, number2};

  always_comb begin
    res = '0;
    unique case (sel)
      3'd1: res = op_a + op_b;
      3'd2: res = op_a - op_b;
      3'd3: res = op_a * op_b;
      3'd4: res = (number2 == '0) ? '1 : op_a / op_b;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_out <= '0;
    else        alu_out <= res;
  end

endmodule

// File: tb/tb_uart_alu_core.sv
// Bench for uart_alu_core: serial RX/TX frames, loopback streaming,
// ALU table, mid-frame reset and a 2-stop-bit build.
module tb_uart_alu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        tx_start = 1'b0;
  logic        tx_start2 = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_in2 = '0;
  logic [7:0]  n1 = '0;
  logic [7:0]  n2 = '0;
  logic [2:0]  sel = '0;
  logic        data_ready, tx_done, tx;
  logic        data_ready2, tx_done2, tx2;
  logic [7:0]  data_out, data_out2;
  logic [14:0] alu_out, alu_out2;
  logic        rx_w;
  logic [1:0]  tdiv = '0;

  int cyc = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;
  int rdy2_cnt = 0;
  int done2_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  rxq[$];
  logic [14:0] aluq[$];
  logic        txq[$];

  assign rx_w = loop ? tx : rx_drv;

  uart_alu_core dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .rx(rx_w), .data_ready(data_ready), .data_out(data_out),
    .tx_start(tx_start), .data_in(data_in),
    .tx_done(tx_done), .tx(tx),
    .number1(n1), .number2(n2), .sel(sel), .alu_out(alu_out)
  );

  uart_alu_core #(.DBITS(8), .SB_TICK(32)) dut2 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .rx(rx_drv), .data_ready(data_ready2), .data_out(data_out2),
    .tx_start(tx_start2), .data_in(data_in2),
    .tx_done(tx_done2), .tx(tx2),
    .number1(n1), .number2(n2), .sel(sel), .alu_out(alu_out2)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tdiv = tdiv + 2'd1;
      sample_tick = (tdiv == 2'd0);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_ready)  rdy_cnt   <= rdy_cnt + 1;
    if (tx_done)     done_cnt  <= done_cnt + 1;
    if (data_ready2) rdy2_cnt  <= rdy2_cnt + 1;
    if (tx_done2)    done2_cnt <= done2_cnt + 1;
  end

  task automatic send_frame(input logic [7:0] b, input int nstop);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (64) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (64*nstop) @(negedge clk);
  endtask

  task automatic test_reset;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx);
    else n_pass++;
    n_chk++;
    if (alu_out !== 15'd0) $display("FAIL rst_alu: got %h want 0", alu_out);
    else n_pass++;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (data_out !== 8'h00) $display("FAIL rst_dout: got %h want 00", data_out);
    else n_pass++;
    n_chk++;
    if (data_ready !== 1'b0) $display("FAIL rst_rdy: got %b want 0", data_ready);
    else n_pass++;
    n_chk++;
    if (tx_done !== 1'b0) $display("FAIL rst_done: got %b want 0", tx_done);
    else n_pass++;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL idle_tx: got %b want 1", tx);
    else n_pass++;
  endtask

  task automatic test_rx;
    int r0, t0, t1;
    bit got;
    logic [7:0] exp;
    r0 = rdy_cnt;
    t1 = 0;
    got = 0;
    @(negedge clk);
    t0 = cyc;
    rxq.push_back(8'h35);
    fork
      send_frame(8'h35, 1);
      begin
        for (int i = 0; i < 800 && !got; i++) begin
          @(negedge clk);
          if (data_ready) begin
            got = 1;
            t1 = cyc;
          end
        end
      end
    join
    exp = rxq.pop_front();
    n_chk++;
    if (!got) $display("FAIL rx_pulse: got none want data_ready");
    else n_pass++;
    n_chk++;
    if (data_out !== exp) $display("FAIL rx_data: got %h want %h", data_out, exp);
    else n_pass++;
    n_chk++;
    if (t1 - t0 < 600 || t1 - t0 > 616)
      $display("FAIL rx_latency: got %0d clks want 600..616", t1 - t0);
    else n_pass++;
    n_chk++;
    if (rdy_cnt - r0 != 1) $display("FAIL rx_count: got %0d want 1", rdy_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_tx;
    int d0, c0, c1;
    bit got;
    logic [7:0] b;
    logic e;
    b = 8'h41;
    d0 = done_cnt;
    c1 = 0;
    @(negedge clk);
    data_in = b;
    tx_start = 1'b1;
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(b[i]);
    txq.push_back(1'b1);
    @(negedge clk);
    tx_start = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
    c0 = cyc;
    n_chk++;
    if (tx !== 1'b0) $display("FAIL tx_startbit: got %b want 0", tx);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 32 : 64) @(negedge clk);
      e = txq.pop_front();
      n_chk++;
      if (tx !== e) $display("FAIL tx_bit%0d: got %b want %b", i, tx, e);
      else n_pass++;
    end
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tx_done) begin
        got = 1;
        c1 = cyc;
      end
    end
    n_chk++;
    if (!got || c1 - c0 < 628 || c1 - c0 > 648)
      $display("FAIL tx_done_time: got %0d clks want 628..648", c1 - c0);
    else n_pass++;
    repeat (40) @(negedge clk);
    n_chk++;
    if (done_cnt - d0 != 1) $display("FAIL tx_done_count: got %0d want 1", done_cnt - d0);
    else n_pass++;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL tx_idle: got %b want 1", tx);
    else n_pass++;
  endtask

  task automatic test_alu;
    logic [7:0]  va[11];
    logic [7:0]  vb[11];
    logic [2:0]  vs[11];
    logic [14:0] ve[11];
    logic [14:0] e;
    va = '{8'd123, 8'd200, 8'd5, 8'd12, 8'd255, 8'd100,
           8'd9, 8'd7, 8'd7, 8'd255, 8'd0};
    vb = '{8'd45, 8'd50, 8'd10, 8'd11, 8'd255, 8'd7,
           8'd0, 8'd3, 8'd3, 8'd255, 8'd1};
    vs = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
           3'd4, 3'd0, 3'd5, 3'd1, 3'd2};
    ve = '{15'd168, 15'd150, 15'h7FFB, 15'd132, 15'd32257, 15'd14,
           15'h7FFF, 15'd0, 15'd0, 15'd510, 15'h7FFF};
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = aluq.pop_front();
        n_chk++;
        if (alu_out !== e) $display("FAIL alu_%0d: got %h want %h", i - 1, alu_out, e);
        else n_pass++;
      end
      if (i < 11) begin
        n1 = va[i];
        n2 = vb[i];
        sel = vs[i];
        aluq.push_back(ve[i]);
      end
    end
    sel = 3'd0;
  endtask

  task automatic test_back_to_back;
    int r0, nrx, ndone, td;
    bit gap_pending;
    logic [7:0] exp;
    loop = 1'b1;
    r0 = rdy_cnt;
    nrx = 0;
    ndone = 0;
    td = 0;
    gap_pending = 0;
    @(negedge clk);
    data_in = 8'h41;
    tx_start = 1'b1;
    rxq.push_back(8'h41);
    rxq.push_back(8'h64);
    rxq.push_back(8'h0A);
    for (int i = 0; i < 3000 && (nrx < 3 || ndone < 3); i++) begin
      @(negedge clk);
      if (gap_pending && tx === 1'b0) begin
        gap_pending = 0;
        n_chk++;
        if (cyc - td != 1) $display("FAIL b2b_gap: got %0d want 1", cyc - td);
        else n_pass++;
      end
      if (data_ready) begin
        nrx++;
        exp = (rxq.size() > 0) ? rxq.pop_front() : 8'hXX;
        n_chk++;
        if (data_out !== exp) $display("FAIL b2b_rx%0d: got %h want %h", nrx, data_out, exp);
        else n_pass++;
      end
      if (tx_done) begin
        ndone++;
        td = cyc;
        if (ndone == 1) begin
          data_in = 8'h64;
          gap_pending = 1;
        end else if (ndone == 2) begin
          data_in = 8'h0A;
          gap_pending = 1;
        end else begin
          tx_start = 1'b0;
        end
      end
    end
    n_chk++;
    if (nrx != 3 || ndone != 3)
      $display("FAIL b2b_frames: got rx %0d done %0d want 3 3", nrx, ndone);
    else n_pass++;
    repeat (100) @(negedge clk);
    n_chk++;
    if (rdy_cnt - r0 != 3) $display("FAIL b2b_count: got %0d want 3", rdy_cnt - r0);
    else n_pass++;
    loop = 1'b0;
  endtask

  task automatic test_reset_mid;
    int r0, d0;
    bit got;
    logic [7:0] exp;
    @(negedge clk);
    n1 = 8'd200;
    n2 = 8'd100;
    sel = 3'd1;
    data_in = 8'h00;
    tx_start = 1'b1;
    rx_drv = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (300) @(negedge clk);
    n_chk++;
    if (tx !== 1'b0 || alu_out !== 15'd300)
      $display("FAIL pre_rst: got tx %b alu %0d want 0 300", tx, alu_out);
    else n_pass++;
    r0 = rdy_cnt;
    d0 = done_cnt;
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL mid_rst_tx: got %b want 1", tx);
    else n_pass++;
    n_chk++;
    if (alu_out !== 15'd0) $display("FAIL mid_rst_alu: got %h want 0", alu_out);
    else n_pass++;
    n_chk++;
    if (data_out !== 8'h00) $display("FAIL mid_rst_dout: got %h want 00", data_out);
    else n_pass++;
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sel = 3'd0;
    repeat (100) @(negedge clk);
    n_chk++;
    if (rdy_cnt != r0 || done_cnt != d0)
      $display("FAIL mid_rst_pulse: got rdy %0d done %0d want 0 0", rdy_cnt - r0, done_cnt - d0);
    else n_pass++;
    got = 0;
    rxq.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1);
      begin
        for (int i = 0; i < 800 && !got; i++) begin
          @(negedge clk);
          if (data_ready) got = 1;
        end
      end
    join
    exp = rxq.pop_front();
    n_chk++;
    if (!got || data_out !== exp)
      $display("FAIL post_rst_rx: got %h (pulse %b) want %h", data_out, got, exp);
    else n_pass++;
  endtask

  task automatic test_sb32;
    int d0, c0, c1, r0;
    bit got;
    logic [7:0] exp;
    d0 = done2_cnt;
    c1 = 0;
    @(negedge clk);
    data_in2 = 8'h5A;
    tx_start2 = 1'b1;
    @(negedge clk);
    tx_start2 = 1'b0;
    for (int i = 0; i < 20 && tx2 !== 1'b0; i++) @(negedge clk);
    c0 = cyc;
    repeat (32 + 64*9) @(negedge clk);
    n_chk++;
    if (tx2 !== 1'b1) $display("FAIL sb32_stop1: got %b want 1", tx2);
    else n_pass++;
    repeat (64) @(negedge clk);
    n_chk++;
    if (tx2 !== 1'b1 || done2_cnt != d0)
      $display("FAIL sb32_stop2: got tx %b done %0d want 1 0", tx2, done2_cnt - d0);
    else n_pass++;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tx_done2) begin
        got = 1;
        c1 = cyc;
      end
    end
    n_chk++;
    if (!got || c1 - c0 < 692 || c1 - c0 > 712)
      $display("FAIL sb32_done_time: got %0d clks want 692..712", c1 - c0);
    else n_pass++;
    r0 = rdy2_cnt;
    got = 0;
    repeat (10) @(negedge clk);
    rxq.push_back(8'hC3);
    fork
      send_frame(8'hC3, 2);
      begin
        for (int i = 0; i < 900 && !got; i++) begin
          @(negedge clk);
          if (data_ready2) got = 1;
        end
      end
    join
    exp = rxq.pop_front();
    n_chk++;
    if (!got || data_out2 !== exp)
      $display("FAIL sb32_rx: got %h (pulse %b) want %h", data_out2, got, exp);
    else n_pass++;
    n_chk++;
    if (rdy2_cnt - r0 != 1) $display("FAIL sb32_rx_count: got %0d want 1", rdy2_cnt - r0);
    else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_rx();
    test_tx();
    test_alu();
    test_back_to_back();
    test_reset_mid();
    test_sb32();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_alu_core.md
Name: uart_alu_core

Overview:
- Datapath core of the serial calculator: UART receiver, UART transmitter and an 8-bit arithmetic unit in one block, sharing one clock and reset.
- A 16x-oversampling tick comes from the external baud-rate generator.
- The surrounding command parser feeds received bytes into the operands and selector, then streams result text out through the transmitter.

Parameters:
- DBITS, 8: data bits per UART frame; also the operand width.
- SB_TICK, 16: sample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-clk pulse at 16x baud rate.
- rx  in  1  serial input; idle high.
- data_ready  out  1  one-clk pulse when a received byte is valid.
- data_out  out  DBITS  last received byte.
- tx_start  in  1  request to send data_in.
- data_in  in  DBITS  byte to transmit.
- tx_done  out  1  one-clk pulse at end of the transmitted stop bit.
- tx  out  1  serial output; idle high.
- number1  in  DBITS  operand A, unsigned.
- number2  in  DBITS  operand B, unsigned.
- sel  in  3  operation select.
- alu_out  out  2*DBITS-1  registered result (15 bits at default).

Behaviour:
- Reset (reset=0, asynchronous):
  - Both UART FSMs go to IDLE; all counters clear.
  - data_out=0, data_ready=0, tx=1, tx_done=0, alu_out=0.
- Receiver FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a falling edge is rx=0 sampled at any clk. Move to START with the tick counter cleared.
  - START: count sample_tick. At tick count 7 (mid start bit), clear counters and go to DATA. No false-start recheck.
  - DATA: at each 16th tick, shift rx into the MSB of the shift register (LSB-first line order). After DBITS bits go to STOP.
  - STOP: after SB_TICK ticks, pulse data_ready for exactly one clk, update data_out to the assembled byte, and return to IDLE.
  - The stop-bit level is not checked; a framing error still produces data_ready.
  - data_out holds its value until the next completed frame.
  - Counters advance only on clks where sample_tick=1.
- Transmitter FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: tx=1. When tx_start=1, latch data_in and go to START.
  - START: tx=0 for 16 ticks.
  - DATA: drive the latched byte LSB first, 16 ticks per bit.
  - STOP: tx=1 for SB_TICK ticks, then pulse tx_done for one clk and return to IDLE.
  - Changes on data_in during a frame have no effect.
  - If tx_start is still high on the clk after tx_done, the next frame starts immediately (back-to-back streaming). tx_start is level-sensitive, sampled only in IDLE.
  - tx is driven from a register (glitch-free).
- ALU: registered on posedge clk, 1-cycle latency from operands/sel to alu_out. Operands zero-extend to 2*DBITS-1 bits before arithmetic.
  - sel=1 ADD: number1+number2.
  - sel=2 SUB: number1-number2, two's complement truncated to 15 bits. 5-10 gives 0x7FFB.
  - sel=3 MUL: number1*number2 (max 255*255=65025 exceeds 15 bits; keep low 15 bits, 32767 wrap).
  - sel=4 DIV: integer quotient number1/number2. Divide by zero gives all ones (0x7FFF).
  - Any other sel: 0.
- Simultaneous activity: RX, TX and ALU are fully independent and may all operate in the same clk.
- Reset mid-frame: the frame is abandoned with no data_ready/tx_done pulse, and tx returns high immediately.

Test Plan:
- RX: send 0x35 at 16x ticks (start, 1,0,1,0,1,1,0,0, stop) -> exactly one data_ready pulse ~ (7+16*8+16) ticks after the start edge; data_out=0x35.
- TX: data_in=0x41, tx_start pulse -> tx line shows 0, then 1,0,0,0,0,0,1,0, then 1, each 16 ticks; tx_done pulses once; tx then idles at 1.
- Loopback tx->rx, tx_start held high with data_in "A","d","\n" changed after each tx_done -> RX receives 0x41,0x64,0x0A with no gaps or errors.
- ALU one cycle after input:
  - 123+45 -> 168.
  - 200-50 -> 150.
  - 12*11 -> 132.
  - 255*255 -> 65025 mod 32768 = 32257.
  - 100/7 -> 14.
  - 9/0 -> 0x7FFF.
  - sel=0 -> 0.
- Reset asserted mid-RX and mid-TX frame -> tx=1 and alu_out=0 immediately; no pulses. The next clean frame after release is received correctly.
- SB_TICK=32 build -> stop bit lasts 32 ticks before tx_done; the receiver accepts a 2-stop-bit frame.
